// File: rtl/bcd_sequencer_8bit_if.sv
// Handshake and result bundle for the 8-bit binary-to-BCD sequencer.
// The master requests conversions; the slave returns the BCD digits.
interface bcd_sequencer_8bit_if;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic       valid;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  valid,
        input  hundreds,
        input  tens,
        input  ones
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output valid,
        output hundreds,
        output tens,
        output ones
    );
endinterface

// File: rtl/bcd_sequencer_8bit.sv
// Converts an 8-bit binary operand into three BCD digits.
// Uses one shared compare-and-subtract step per clock: first by 100, then by 10.
module bcd_sequencer_8bit (
    input  logic                        clk,
    input  logic                        rst_n,
    bcd_sequencer_8bit_if.slave         bus
);

    typedef enum logic [1:0] {
        StIdle,
        StHund,
        StTens,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] residue_q, residue_d;
    logic [3:0] h_cnt_q, h_cnt_d;
    logic [3:0] t_cnt_q, t_cnt_d;
    logic [3:0] hundreds_q, hundreds_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       valid_q, valid_d;

    // Single subtractor; the constant is selected by the current digit phase.
    logic [7:0] sub_k;
    logic       sub_ge;
    logic [7:0] sub_diff;

    assign sub_k    = (state_q == StHund) ? 8'd100 : 8'd10;
    assign sub_ge   = (residue_q >= sub_k);
    assign sub_diff = residue_q - sub_k;

    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        h_cnt_d    = h_cnt_q;
        t_cnt_d    = t_cnt_q;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        valid_d    = valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    residue_d = bus.bin;
                    h_cnt_d   = 4'd0;
                    t_cnt_d   = 4'd0;
                    valid_d   = 1'b0;
                    state_d   = StHund;
                end
            end
            StHund: begin
                if (sub_ge) begin
                    residue_d = sub_diff;
                    h_cnt_d   = h_cnt_q + 4'd1;
                end else begin
                    state_d = StTens;
                end
            end
            StTens: begin
                if (sub_ge) begin
                    residue_d = sub_diff;
                    t_cnt_d   = t_cnt_q + 4'd1;
                end else begin
                    // Results and valid publish together so valid rises with done.
                    hundreds_d = h_cnt_q;
                    tens_d     = t_cnt_q;
                    ones_d     = residue_q[3:0];
                    valid_d    = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            residue_q  <= 8'd0;
            h_cnt_q    <= 4'd0;
            t_cnt_q    <= 4'd0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            residue_q  <= residue_d;
            h_cnt_q    <= h_cnt_d;
            t_cnt_q    <= t_cnt_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.valid    = valid_q;
    assign bus.hundreds = hundreds_q;
    assign bus.tens     = tens_q;
    assign bus.ones     = ones_q;

endmodule
